pipe_ifid: RTL and testbench

PIPE_IFID -- requirements
Module: pipe_ifid

---
 rtl/pipe_ifid_pkg.sv | 24 ++
 rtl/pipe_ifid_sat_counter.sv | 24 ++
 rtl/pipe_ifid.sv | 83 ++++++++
 tb/tb_pipe_ifid.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ifid_pkg.sv
// Shared pipeline constants for the IF/ID stage: instruction/PC widths, bubble word,
// default counter width, and the classification of an IF/ID register update.
package pipe_ifid_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int IFID_CNT_W = 32;
    localparam logic [INST_W-1:0] IFID_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

    // Flush outranks stall; an unstalled edge without a real instruction loads a bubble.
    function automatic ifid_op_e ifid_op(input logic stall, input logic flush, input logic valid);
        if (flush)      return IFID_BUBBLE;
        else if (stall) return IFID_HOLD;
        else if (valid) return IFID_LOAD;
        else            return IFID_BUBBLE;
    endfunction

endpackage

// File: rtl/pipe_ifid_sat_counter.sv
// Saturating event counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ifid.sv
// IF/ID pipeline register with stall hold, flush squash and bubble insertion.
// Optional stall/flush performance counters are built only when IFID_PERF_CNT_EN is defined.
module pipe_ifid
    import pipe_ifid_pkg::*;
#(
    parameter int                CNT_W    = IFID_CNT_W,
    parameter logic [INST_W-1:0] NOP_INST = IFID_NOP_INST
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_pc8,
    input  logic              stall,
    input  logic              flush,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc8
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    ifid_op_e          w_op;
    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pc8;

    assign w_op = ifid_op(stall, flush, if_valid);

    // Bubbles always carry NOP_INST and a zero link address, so an invalid entry is never mistaken for real work.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc8   <= '0;
        end else begin
            case (w_op)
                IFID_LOAD: begin
                    r_valid <= 1'b1;
                    r_inst  <= if_inst;
                    r_pc8   <= if_pc8;
                end
                IFID_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_inst  <= NOP_INST;
                    r_pc8   <= '0;
                end
                default: begin
                    r_valid <= r_valid;
                    r_inst  <= r_inst;
                    r_pc8   <= r_pc8;
                end
            endcase
        end
    end

    assign id_valid = r_valid;
    assign id_inst  = r_inst;
    assign id_pc8   = r_pc8;

`ifdef IFID_PERF_CNT_EN
    logic w_stall_ev;
    assign w_stall_ev = stall & ~flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .i_en  (w_stall_ev),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .i_en  (flush),
        .o_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ifid.sv
// Self-checking bench for pipe_ifid: directed cases, randomized traffic against a
// rule-level reference model, and a standalone 4-bit sat_counter saturation check.
module tb_pipe_ifid;

    logic        clk = 1'b0;
    logic        clrn;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc8;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc8;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    logic        sat_en;
    logic [3:0]  sat_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc8;
    longint      exp_stall_n;
    longint      exp_flush_n;

    always #5 clk = ~clk;

    pipe_ifid dut (
        .clk      (clk),
        .clrn     (clrn),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .if_pc8   (if_pc8),
        .stall    (stall),
        .flush    (flush),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc8   (id_pc8)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    sat_counter #(.W(4)) u_sat4 (
        .clk   (clk),
        .clrn  (clrn),
        .i_en  (sat_en),
        .o_cnt (sat_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_valid   = 1'b0;
        exp_inst    = 32'h0;
        exp_pc8     = 32'h0;
        exp_stall_n = 0;
        exp_flush_n = 0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic v,
                              input logic [31:0] inst, input logic [31:0] pc);
        if (f) begin
            exp_valid = 1'b0; exp_inst = 32'h0; exp_pc8 = 32'h0;
            exp_flush_n++;
        end else if (s) begin
            exp_stall_n++;
        end else if (v) begin
            exp_valid = 1'b1; exp_inst = inst; exp_pc8 = pc;
        end else begin
            exp_valid = 1'b0; exp_inst = 32'h0; exp_pc8 = 32'h0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, {63'd0, id_valid}, {63'd0, exp_valid});
        chk({tag, "_inst"},  {32'd0, id_inst},  {32'd0, exp_inst});
        chk({tag, "_pc8"},   {32'd0, id_pc8},   {32'd0, exp_pc8});
`ifdef IFID_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, {32'd0, stall_cnt},
            (exp_stall_n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(exp_stall_n));
        chk({tag, "_flush_cnt"}, {32'd0, flush_cnt},
            (exp_flush_n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(exp_flush_n));
`endif
    endtask

    // Drive inputs just after an edge, apply the next edge, update the model, sample 1 ns later.
    task automatic step(input string tag, input logic s, input logic f, input logic v,
                        input logic [31:0] inst, input logic [31:0] pc);
        stall = s; flush = f; if_valid = v; if_inst = inst; if_pc8 = pc;
        @(posedge clk);
        model_edge(s, f, v, inst, pc);
        #1;
        check_all(tag);
    endtask

    initial begin
        clrn = 1'b0; stall = 1'b0; flush = 1'b0; if_valid = 1'b1;
        if_inst = 32'hDEAD_BEEF; if_pc8 = 32'h1234_5678; sat_en = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("sat4_reset", {60'd0, sat_cnt}, 64'd0);
        clrn = 1'b1;

        // Load, 3-cycle stall with changing fetch word, flush over stall, bubble
        step("load", 1'b0, 1'b0, 1'b1, 32'h2008_0005, 32'h0000_0010);
        step("stall1", 1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0014);
        step("stall2", 1'b1, 1'b0, 1'b1, 32'h2222_2222, 32'h0000_0018);
        step("stall3", 1'b1, 1'b0, 1'b0, 32'h3333_3333, 32'h0000_001C);
        step("flush_over_stall", 1'b1, 1'b1, 1'b1, 32'h4444_4444, 32'h0000_0020);
        step("bubble", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("bubble_stall", 1'b1, 1'b0, 1'b1, 32'h5555_5555, 32'h0000_0024);
        step("reload", 1'b0, 1'b0, 1'b1, 32'h8C43_0004, 32'h0000_0030);
        step("pre_rst_stall", 1'b1, 1'b0, 1'b1, 32'h6666_6666, 32'h0000_0034);

        // Asynchronous reset between edges discards the held entry
        clrn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        clrn = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b1, 32'h7777_7777, 32'h0000_0040);
        step("post_rst_load", 1'b0, 1'b0, 1'b1, 32'hAC22_0008, 32'h0000_0044);

        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                 $urandom, $urandom);
        end

        // Standalone 4-bit counter must stop at 4'hF
        stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
        sat_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            model_edge(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            chk("sat4_count", {60'd0, sat_cnt}, (k < 15) ? 64'(k) : 64'd15);
        end
        sat_en = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("sat4_hold", {60'd0, sat_cnt}, 64'd15);
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
